// File: rtl/stream_arb_mux_pkg.sv
// Shared types and helpers for the stream arbiter/mux: FSM state encoding
// and the ceil-log2 used to validate the grant index width.
package stream_arb_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// Bundle of the per-channel input streams and the single muxed output stream.
// The slave modport is the arbiter's view; master is the traffic source/sink.
interface stream_arb_mux_if #(
  parameter int data_width = 8,
  parameter int num_inputs = 4,
  parameter int sel_width  = 2
);
  logic [num_inputs*data_width-1:0] i_data;
  logic [num_inputs-1:0]            i_valid;
  logic [num_inputs-1:0]            i_last;
  logic [num_inputs-1:0]            o_ready;
  logic [data_width-1:0]            o_data;
  logic                             o_valid;
  logic                             o_last;
  logic [sel_width-1:0]             o_grant;
  logic                             i_ready;

  modport slave (
    input  i_data, i_valid, i_last, i_ready,
    output o_ready, o_data, o_valid, o_last, o_grant
  );

  modport master (
    output i_data, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_grant
  );
endinterface

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to channel 0; returns one-hot grant and its index.
module stream_arb_mux_rr_arbiter #(
  parameter int num_inputs = 4,
  parameter int sel_width  = 2
) (
  input  logic [num_inputs-1:0] req,
  input  logic [sel_width-1:0]  ptr,
  output logic [num_inputs-1:0] gnt,
  output logic [sel_width-1:0]  gnt_idx,
  output logic                  gnt_vld
);

  logic [num_inputs-1:0] req_rot;
  logic [sel_width:0]    sum;

  always_comb begin
    req_rot = num_inputs'({req, req} >> ptr);
    gnt_vld = 1'b0;
    sum     = '0;
    // descending scan so the lowest rotated offset wins
    for (int i = num_inputs - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, ptr} + (sel_width+1)'(i);
      end
    end
    if (sum >= (sel_width+1)'(num_inputs)) sum = sum - (sel_width+1)'(num_inputs);
    gnt_idx = sum[sel_width-1:0];
    gnt     = gnt_vld ? ({{(num_inputs-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-aware N:1 stream mux: round-robin between packets, locked to one
// channel until its last beat, with a single registered output stage.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int data_width = 8,
  parameter int num_inputs = 4,
  parameter int sel_width  = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  stream_arb_mux_if.slave bus
);

  if (sel_width != clog2_f(num_inputs)) begin : g_bad_sel_width
    $error("sel_width must equal ceil(log2(num_inputs))");
  end
  if (data_width < 1 || data_width > 64 || num_inputs < 2 || num_inputs > 16) begin : g_bad_range
    $error("data_width or num_inputs out of range");
  end

  arb_state_e            state_q, state_d;
  logic [sel_width-1:0]  lock_ch_q, lock_ch_d;
  logic [sel_width-1:0]  rr_ptr_q, rr_ptr_d;
  logic [data_width-1:0] o_data_q, o_data_d;
  logic                  o_valid_q, o_valid_d;
  logic                  o_last_q, o_last_d;
  logic [sel_width-1:0]  o_grant_q, o_grant_d;

  logic                  load, xfer, sel_last, gnt_vld;
  logic [num_inputs-1:0] req, gnt, lock_mask;
  logic [sel_width-1:0]  arb_ptr, gnt_idx;
  logic [data_width-1:0] sel_data;

  assign load      = !o_valid_q || bus.i_ready;
  assign lock_mask = {{(num_inputs-1){1'b0}}, 1'b1} << lock_ch_q;
  // while locked, pointing the arbiter at lock_ch with a masked request
  // makes it grant the locked channel or nothing
  assign req       = (state_q == LOCKED) ? (bus.i_valid & lock_mask) : bus.i_valid;
  assign arb_ptr   = (state_q == LOCKED) ? lock_ch_q : rr_ptr_q;

  stream_arb_mux_rr_arbiter #(
    .num_inputs (num_inputs),
    .sel_width  (sel_width)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (arb_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign xfer        = load && gnt_vld;
  assign bus.o_ready = (xfer && i_rst_n) ? gnt : '0;
  assign sel_data    = data_width'(bus.i_data >> (int'(gnt_idx) * data_width));
  assign sel_last    = |(bus.i_last & gnt);

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_grant_d = o_grant_q;
    if (load) begin
      o_valid_d = xfer;
      if (xfer) begin
        o_data_d  = sel_data;
        o_last_d  = sel_last;
        o_grant_d = gnt_idx;
        if (sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_idx == sel_width'(num_inputs - 1)) ? '0 : gnt_idx + sel_width'(1);
        end else begin
          state_d   = LOCKED;
          lock_ch_d = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_grant_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_grant_q <= o_grant_d;
    end
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_grant = o_grant_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: directed scenarios plus a randomized run checked
// against a packet-level reference model (owner channel + next-priority).
module tb_stream_arb_mux;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  stream_arb_mux_if #(.data_width(DW), .num_inputs(N), .sel_width(SW)) bus();

  stream_arb_mux #(.data_width(DW), .num_inputs(N), .sel_width(SW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // source side: per-channel beat queues {last, data}; gap forces valid low
  logic [8:0]    chq[N][$];
  logic [N-1:0]  gap = '0;
  logic [N-1:0]  acc = '0;

  // reference model
  int            m_owner;
  int            m_next;
  logic          m_ov, m_ol;
  logic [7:0]    m_od;
  logic [1:0]    m_og;
  logic [N-1:0]  exp_ready;
  int            exp_g;

  function automatic void model_reset();
    m_owner = -1; m_next = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_og = '0;
  endfunction

  function automatic void model_comb();
    exp_ready = '0;
    exp_g     = -1;
    if (!m_ov || bus.i_ready) begin
      if (m_owner >= 0) begin
        if (bus.i_valid[m_owner]) exp_g = m_owner;
      end else begin
        for (int j = 0; j < N; j++) begin
          int k;
          k = (m_next + j) % N;
          if (exp_g < 0 && bus.i_valid[k]) exp_g = k;
        end
      end
      if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    end
  endfunction

  function automatic void model_seq();
    if (!m_ov || bus.i_ready) begin
      m_ov = (exp_g >= 0);
      if (exp_g >= 0) begin
        m_od = bus.i_data[exp_g*DW +: DW];
        m_ol = bus.i_last[exp_g];
        m_og = 2'(exp_g);
        if (m_ol) begin
          m_owner = -1;
          m_next  = (exp_g + 1) % N;
        end else begin
          m_owner = exp_g;
        end
      end
    end
  endfunction

  task automatic present();
    for (int k = 0; k < N; k++) begin
      if (chq[k].size() > 0 && !gap[k]) begin
        bus.i_valid[k]            = 1'b1;
        bus.i_data[k*DW +: DW]    = chq[k][0][7:0];
        bus.i_last[k]             = chq[k][0][8];
      end else begin
        bus.i_valid[k] = 1'b0;
        bus.i_last[k]  = 1'b0;
      end
    end
    #1;
    model_comb();
  endtask

  task automatic advance();
    acc = bus.o_ready & bus.i_valid;
    @(posedge i_clk);
    model_seq();
    for (int k = 0; k < N; k++) if (acc[k]) void'(chq[k].pop_front());
    #1;
  endtask

  task automatic test_reset();
    bus.i_valid = '1; bus.i_last = '1; bus.i_data = 32'hA5A5_A5A5; bus.i_ready = 1'b1;
    #2 i_rst_n = 1'b0;
    #2;
    n_asserts++;
    if ({bus.o_valid, bus.o_last, bus.o_grant, bus.o_data} !== 12'h000) begin
      n_fail++; $display("FAIL reset_async_outputs got v=%b l=%b g=%0d d=%h exp all zero",
                         bus.o_valid, bus.o_last, bus.o_grant, bus.o_data);
    end
    n_asserts++;
    if (bus.o_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got %b exp 0000", bus.o_ready);
    end
    repeat (2) @(posedge i_clk);
    #1;
    n_asserts++;
    if ({bus.o_valid, bus.o_ready, bus.o_data} !== 13'h0) begin
      n_fail++; $display("FAIL reset_held got v=%b r=%b d=%h exp 0/0000/00", bus.o_valid, bus.o_ready, bus.o_data);
    end
    bus.i_valid = '0; bus.i_last = '0; bus.i_data = '0;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    int eg[5] = '{0, 1, 2, 3, 0};
    chq[0].push_back({1'b1, 8'h10});
    for (int k = 0; k < N; k++) chq[k].push_back({1'b1, 8'(8'h10 + k)});
    bus.i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      present();
      n_asserts++;
      if (bus.o_ready !== exp_ready) begin
        n_fail++; $display("FAIL rr_ready c%0d got %b exp %b", c, bus.o_ready, exp_ready);
      end
      advance();
      n_asserts++;
      if (c < 5) begin
        if ({bus.o_valid, bus.o_grant, bus.o_data} !== {1'b1, 2'(eg[c]), 8'(8'h10 + eg[c])}) begin
          n_fail++; $display("FAIL rr_out c%0d got v=%b g=%0d d=%h exp v=1 g=%0d d=%h",
                             c, bus.o_valid, bus.o_grant, bus.o_data, eg[c], 8'h10 + eg[c]);
        end
      end else if (bus.o_valid !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle got v=%b exp 0", bus.o_valid);
      end
    end
  endtask

  task automatic test_packet_lock();
    int         eg[5] = '{2, 2, 2, 3, 0};
    logic [7:0] ed[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hB0};
    logic       el[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    chq[2].push_back({1'b0, 8'hA0}); chq[2].push_back({1'b0, 8'hA1}); chq[2].push_back({1'b1, 8'hA2});
    chq[0].push_back({1'b1, 8'hB0});
    chq[3].push_back({1'b1, 8'hC0});
    for (int c = 0; c < 5; c++) begin
      present();
      n_asserts++;
      if (bus.o_ready !== (4'b0001 << eg[c])) begin
        n_fail++; $display("FAIL lock_ready c%0d got %b exp ch%0d", c, bus.o_ready, eg[c]);
      end
      advance();
      n_asserts++;
      if ({bus.o_valid, bus.o_last, bus.o_grant, bus.o_data} !== {1'b1, el[c], 2'(eg[c]), ed[c]}) begin
        n_fail++; $display("FAIL lock_out c%0d got v=%b l=%b g=%0d d=%h exp v=1 l=%b g=%0d d=%h",
                           c, bus.o_valid, bus.o_last, bus.o_grant, bus.o_data, el[c], eg[c], ed[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    chq[1].push_back({1'b1, 8'h51}); chq[1].push_back({1'b1, 8'h52});
    for (int c = 0; c < 8; c++) begin
      bus.i_ready = (c == 0 || c >= 6);
      present();
      n_asserts++;
      if (bus.o_ready !== ((c == 0 || c == 6) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL bp_ready c%0d got %b", c, bus.o_ready);
      end
      advance();
      n_asserts++;
      if (c < 7) begin
        if ({bus.o_valid, bus.o_last, bus.o_grant, bus.o_data} !== {1'b1, 1'b1, 2'd1, (c < 6) ? 8'h51 : 8'h52}) begin
          n_fail++; $display("FAIL bp_out c%0d got v=%b l=%b g=%0d d=%h exp held/next ch1 beat",
                             c, bus.o_valid, bus.o_last, bus.o_grant, bus.o_data);
        end
      end else if (bus.o_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_drain got v=%b exp 0", bus.o_valid);
      end
    end
  endtask

  task automatic test_wrap_gap();
    logic [3:0] er[7] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001};
    logic       ev[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         eg[7] = '{3, 1, 0, 0, 1, 1, 0};
    logic [7:0] ed[7] = '{8'h3F, 8'h61, 8'h00, 8'h00, 8'h62, 8'h63, 8'h0A};
    bus.i_ready = 1'b1;
    chq[3].push_back({1'b1, 8'h3F});
    chq[1].push_back({1'b0, 8'h61}); chq[1].push_back({1'b0, 8'h62}); chq[1].push_back({1'b1, 8'h63});
    for (int c = 0; c < 7; c++) begin
      gap[1] = (c == 0 || c == 2 || c == 3);
      if (c == 2) chq[0].push_back({1'b1, 8'h0A});
      present();
      n_asserts++;
      if (bus.o_ready !== er[c]) begin
        n_fail++; $display("FAIL wrap_ready c%0d got %b exp %b", c, bus.o_ready, er[c]);
      end
      advance();
      n_asserts++;
      if (bus.o_valid !== ev[c] || (ev[c] && {bus.o_grant, bus.o_data} !== {2'(eg[c]), ed[c]})) begin
        n_fail++; $display("FAIL wrap_out c%0d got v=%b g=%0d d=%h exp v=%b g=%0d d=%h",
                           c, bus.o_valid, bus.o_grant, bus.o_data, ev[c], eg[c], ed[c]);
      end
    end
    gap = '0;
  endtask

  task automatic test_reset_mid();
    chq[1].push_back({1'b0, 8'h71}); chq[1].push_back({1'b0, 8'h72}); chq[1].push_back({1'b1, 8'h73});
    present();
    advance();
    chq[0].push_back({1'b1, 8'h05});
    present();
    n_asserts++;
    if (bus.o_ready !== 4'b0010 || bus.o_data !== 8'h71) begin
      n_fail++; $display("FAIL mid_beat2 got r=%b d=%h exp 0010/71", bus.o_ready, bus.o_data);
    end
    #1 i_rst_n = 1'b0;
    #1;
    n_asserts++;
    if ({bus.o_valid, bus.o_ready, bus.o_data} !== 13'h0) begin
      n_fail++; $display("FAIL mid_reset got v=%b r=%b d=%h exp 0/0000/00", bus.o_valid, bus.o_ready, bus.o_data);
    end
    chq[1].delete();
    chq[2].push_back({1'b1, 8'h22});
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      present();
      advance();
      n_asserts++;
      if (bus.o_valid !== (c < 2) || (c < 2 && {bus.o_grant, bus.o_data} !== ((c == 0) ? {2'd0, 8'h05} : {2'd2, 8'h22}))) begin
        n_fail++; $display("FAIL mid_restart c%0d got v=%b g=%0d d=%h", c, bus.o_valid, bus.o_grant, bus.o_data);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (chq[k].size() == 0 && $urandom_range(0, 2) == 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) chq[k].push_back({(b == len - 1), 8'($urandom)});
        end
        if (!bus.i_valid[k] || acc[k]) gap[k] = ($urandom_range(0, 4) == 0);
      end
      bus.i_ready = ($urandom_range(0, 3) != 0);
      present();
      n_asserts++;
      if (bus.o_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready c%0d got %b exp %b", c, bus.o_ready, exp_ready);
      end
      advance();
      n_asserts++;
      if (bus.o_valid !== m_ov || (m_ov && {bus.o_last, bus.o_grant, bus.o_data} !== {m_ol, m_og, m_od})) begin
        n_fail++; $display("FAIL rand_out c%0d got v=%b l=%b g=%0d d=%h exp v=%b l=%b g=%0d d=%h",
                           c, bus.o_valid, bus.o_last, bus.o_grant, bus.o_data, m_ov, m_ol, m_og, m_od);
      end
    end
  endtask

  initial begin
    bus.i_valid = '0; bus.i_last = '0; bus.i_data = '0; bus.i_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap_gap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
